// File: rtl/imm_control_sequencer.sv
// imm_control_sequencer: hardwired T0-T5 control sequencer covering instruction
// fetch and the immediate family (ldi, addi, andi, ori, halt) with memory wait,
// run/idle handshake, illegal-opcode trap and a retired-instruction counter.
//
//   state | meaning
//   IDLE  | no activity; leaves for T0 when run is high
//   T0    | PC onto bus, load MAR
//   T1    | memory read, held MEM_WAIT+1 cycles; PC increments in the last one
//   T2    | MDR onto bus, load IR
//   T3    | decode IR opcode; ldi/alu-imm operand into Y, halt/undefined trap
//   T4    | ALU operation into Z
//   T5    | Z_LO written back to Ra; instruction retires
//   HALT  | terminal until reset; illegal flags an undefined opcode
module imm_control_sequencer #(
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned COUNT_W  = 16,
   parameter logic [4:0]  OP_LDI   = 5'b01000,
   parameter logic [4:0]  OP_ADDI  = 5'b01001,
   parameter logic [4:0]  OP_ANDI  = 5'b01010,
   parameter logic [4:0]  OP_ORI   = 5'b01011,
   parameter logic [4:0]  OP_HALT  = 5'b11011,
   parameter logic [4:0]  ALU_LDI  = 5'b00001,
   parameter logic [4:0]  ALU_ADD  = 5'b00011,
   parameter logic [4:0]  ALU_AND  = 5'b00101,
   parameter logic [4:0]  ALU_OR   = 5'b00110
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               run,
   input  logic [31:0]        IR_Data,
   output logic               PC_select,
   output logic               MAR_enable,
   output logic               PC_increment_enable,
   output logic               read,
   output logic               MDR_enable,
   output logic               MDR_select,
   output logic               IR_enable,
   output logic               Gra,
   output logic               Grb,
   output logic               ba_select,
   output logic               r_select,
   output logic               r_enable,
   output logic               c_select,
   output logic               Y_enable,
   output logic               Z_enable,
   output logic               Z_LO_select,
   output logic               write,
   output logic [4:0]         alu_instruction,
   output logic               busy,
   output logic               halted,
   output logic               illegal,
   output logic [COUNT_W-1:0] instr_count,
   output logic [3:0]         state
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3,
      S_T3   = 4'd4, S_T4 = 4'd5, S_T5 = 4'd6, S_HALT = 4'd7
   } state_e;

   localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

   state_e             state_q;
   logic [3:0]         wait_q;
   logic [4:0]         op_q;
   logic [COUNT_W-1:0] count_q;
   logic               illegal_q;

   logic [4:0] ir_op;
   logic       ir_legal;
   logic       unused_ir;

   // IR is loaded by the datapath at the end of T2, so T3 decodes it live
   // and the opcode is latched on the T3 exit edge for T4/T5.
   assign ir_op     = IR_Data[31:27];
   assign ir_legal  = (ir_op == OP_LDI) || (ir_op == OP_ADDI) ||
                      (ir_op == OP_ANDI) || (ir_op == OP_ORI);
   assign unused_ir = ^IR_Data[26:0];

   // State, wait counter, opcode latch, retire counter and trap flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         op_q      <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (run) state_q <= S_T0;
            S_T0: begin
               wait_q  <= WAIT_INIT;
               state_q <= S_T1;
            end
            S_T1: begin
               if (wait_q == 4'd0) state_q <= S_T2;
               else                wait_q  <= wait_q - 4'd1;
            end
            S_T2: state_q <= S_T3;
            S_T3: begin
               op_q <= ir_op;
               if (ir_legal) begin
                  state_q <= S_T4;
               end else begin
                  state_q   <= S_HALT;
                  illegal_q <= (ir_op != OP_HALT);
               end
            end
            S_T4: state_q <= S_T5;
            S_T5: begin
               count_q <= count_q + COUNT_W'(1);
               state_q <= run ? S_T0 : S_IDLE;
            end
            S_HALT: state_q <= S_HALT;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Moore decode of the control word from state, wait counter and opcode.
   always_comb begin
      PC_select           = 1'b0;
      MAR_enable          = 1'b0;
      PC_increment_enable = 1'b0;
      read                = 1'b0;
      MDR_enable          = 1'b0;
      MDR_select          = 1'b0;
      IR_enable           = 1'b0;
      Gra                 = 1'b0;
      Grb                 = 1'b0;
      ba_select           = 1'b0;
      r_select            = 1'b0;
      r_enable            = 1'b0;
      c_select            = 1'b0;
      Y_enable            = 1'b0;
      Z_enable            = 1'b0;
      Z_LO_select         = 1'b0;
      alu_instruction     = 5'b00000;
      case (state_q)
         S_T0: begin
            PC_select  = 1'b1;
            MAR_enable = 1'b1;
         end
         S_T1: begin
            read                = 1'b1;
            MDR_enable          = 1'b1;
            PC_increment_enable = (wait_q == 4'd0);
         end
         S_T2: begin
            MDR_select = 1'b1;
            IR_enable  = 1'b1;
         end
         S_T3: begin
            if (ir_op == OP_LDI) begin
               Grb       = 1'b1;
               ba_select = 1'b1;
               Y_enable  = 1'b1;
            end else if (ir_legal) begin
               c_select = 1'b1;
               Y_enable = 1'b1;
            end
         end
         S_T4: begin
            Z_enable = 1'b1;
            if (op_q == OP_LDI) begin
               c_select        = 1'b1;
               alu_instruction = ALU_LDI;
            end else begin
               Grb      = 1'b1;
               r_select = 1'b1;
               if (op_q == OP_ADDI)      alu_instruction = ALU_ADD;
               else if (op_q == OP_ANDI) alu_instruction = ALU_AND;
               else                      alu_instruction = ALU_OR;
            end
         end
         S_T5: begin
            Z_LO_select = 1'b1;
            Gra         = 1'b1;
            r_enable    = 1'b1;
         end
         default: ;
      endcase
   end

   assign write       = 1'b0;
   assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted      = (state_q == S_HALT);
   assign illegal     = illegal_q;
   assign instr_count = count_q;
   assign state       = state_q;

endmodule
